cpu_clock_controller: RTL and testbench

Run/halt/single-step controller for the soft RISC-V core clock enable. It generates a one-cycle `cpu_ce` pulse train from the board clock, in one of three modes: free-running at a selectable rate, halted, or single-stepped from a debounced push-button. It sits between the board I/O (switch, button, rate selector) and the core's clock-enable input. It also exposes a heartbeat LED and a 32-bit count of issued enables for the debug display.

---
 rtl/cpu_clock_controller.sv | 179 +++++++++++++++++
 tb/tb_cpu_clock_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_controller.sv
// Run/halt/single-step clock-enable generator for the soft core.
// Produces one-cycle cpu_ce pulses free-running at a selectable period or on a debounced step press.
module cpu_clock_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 250_000,
    parameter int unsigned RATE0           = 1,
    parameter int unsigned RATE1           = 25_000,
    parameter int unsigned RATE2           = 2_500_000,
    parameter int unsigned RATE3           = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_req,
    input  logic        step_btn,
    input  logic        halt_req,
    input  logic [1:0]  rate_sel,
    output logic        cpu_ce,
    output logic        running,
    output logic        halt_lock,
    output logic        cpu_clk_vis,
    output logic [31:0] tick_count
);

    localparam int unsigned MAX_01   = (RATE0 > RATE1) ? RATE0 : RATE1;
    localparam int unsigned MAX_23   = (RATE2 > RATE3) ? RATE2 : RATE3;
    localparam int unsigned MAX_RATE = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;
    localparam int unsigned CNT_W    = (MAX_RATE > 1) ? $clog2(MAX_RATE) : 1;
    localparam int unsigned DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             run_p0;
    logic             run_s;
    logic             step_p0;
    logic             step_s;
    logic             step_db;
    logic             step_db_p1;
    logic             step_ev;
    logic [DB_W-1:0]  db_cnt;

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] period_m1;
    logic [31:0]      tick_reg;

    logic             ce_nxt;
    logic             running_nxt;
    logic             lock_nxt;
    logic             enter_run;
    logic             wrap;

    // Period minus one, so the divider compares directly against its own count.
    function automatic logic [CNT_W-1:0] rate_m1(input logic [1:0] sel);
        logic [CNT_W-1:0] r;
        case (sel)
            2'd0:    r = CNT_W'(RATE0 - 1);
            2'd1:    r = CNT_W'(RATE1 - 1);
            2'd2:    r = CNT_W'(RATE2 - 1);
            default: r = CNT_W'(RATE3 - 1);
        endcase
        return r;
    endfunction

    // Stage p0 -> s: two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_p0  <= 1'b0;
            run_s   <= 1'b0;
            step_p0 <= 1'b0;
            step_s  <= 1'b0;
        end else begin
            run_p0  <= run_req;
            run_s   <= run_p0;
            step_p0 <= step_btn;
            step_s  <= step_p0;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt     <= '0;
            step_db    <= 1'b0;
            step_db_p1 <= 1'b0;
            step_ev    <= 1'b0;
        end else begin
            if (step_s == step_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt  <= '0;
                step_db <= step_s;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            step_db_p1 <= step_db;
            step_ev    <= step_db & ~step_db_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HALT;
        end else begin
            state <= state_nxt;
        end
    end

    // A step event beats a run request when both are pending in HALT.
    always_comb begin
        state_nxt = state;
        case (state)
            S_HALT: begin
                if (step_ev) begin
                    state_nxt = S_STEP;
                end else if (run_s && !halt_lock) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_req || !run_s) begin
                    state_nxt = S_HALT;
                end
            end
            S_STEP:  state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase
    end

    // cpu_ce is registered alongside the state, so it is high exactly while in STEP or on a RUN wrap.
    always_comb begin
        enter_run   = (state != S_RUN) && (state_nxt == S_RUN);
        wrap        = (state == S_RUN) && (div_cnt == period_m1);
        ce_nxt      = (state_nxt == S_STEP) || (wrap && (state_nxt == S_RUN));
        running_nxt = (state_nxt == S_RUN);
        lock_nxt    = halt_lock;
        if (halt_req) begin
            lock_nxt = 1'b1;
        end else if (!run_s) begin
            lock_nxt = 1'b0;
        end
    end

    // Divider: rate_sel is only sampled on RUN entry or at a period wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            period_m1 <= '0;
        end else if (enter_run || wrap) begin
            div_cnt   <= '0;
            period_m1 <= rate_m1(rate_sel);
        end else if (state == S_RUN) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ce      <= 1'b0;
            running     <= 1'b0;
            halt_lock   <= 1'b0;
            cpu_clk_vis <= 1'b0;
            tick_reg    <= '0;
        end else begin
            cpu_ce      <= ce_nxt;
            running     <= running_nxt;
            halt_lock   <= lock_nxt;
            cpu_clk_vis <= cpu_clk_vis ^ ce_nxt;
            tick_reg    <= tick_reg + {31'b0, ce_nxt};
        end
    end

    assign tick_count = tick_reg;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller with scaled-down rates and debounce length.
module tb_cpu_clock_controller;

    localparam int unsigned DB = 16;
    localparam int unsigned R0 = 1;
    localparam int unsigned R1 = 5;
    localparam int unsigned R2 = 12;
    localparam int unsigned R3 = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_req = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt_req = 1'b0;
    logic [1:0]  rate_sel = 2'd0;
    logic        cpu_ce;
    logic        running;
    logic        halt_lock;
    logic        cpu_clk_vis;
    logic [31:0] tick_count;

    int checks = 0;
    int failures = 0;

    logic ce_log  [0:127];
    logic run_log [0:127];
    logic lk_log  [0:127];

    cpu_clock_controller #(
        .DEBOUNCE_CYCLES(DB),
        .RATE0(R0),
        .RATE1(R1),
        .RATE2(R2),
        .RATE3(R3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run_req(run_req),
        .step_btn(step_btn),
        .halt_req(halt_req),
        .rate_sel(rate_sel),
        .cpu_ce(cpu_ce),
        .running(running),
        .halt_lock(halt_lock),
        .cpu_clk_vis(cpu_clk_vis),
        .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        run_req  = 1'b0;
        step_btn = 1'b0;
        halt_req = 1'b0;
        rate_sel = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic log_cycle(input int k);
        @(negedge clk);
        ce_log[k]  = cpu_ce;
        run_log[k] = running;
        lk_log[k]  = halt_lock;
    endtask

    // Count pulses in ce_log[1..n] and return the first three positions (0 if absent).
    task automatic scan(input int n, output int cnt, output int p1, output int p2, output int p3);
        cnt = 0; p1 = 0; p2 = 0; p3 = 0;
        for (int i = 1; i <= n; i++) begin
            if (ce_log[i]) begin
                cnt++;
                if (cnt == 1) p1 = i;
                if (cnt == 2) p2 = i;
                if (cnt == 3) p3 = i;
            end
        end
    endtask

    initial begin
        int cnt, p1, p2, p3;
        int seen_ce, seen_run;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ce", {31'b0, cpu_ce}, 32'd0);
        check("rst_running", {31'b0, running}, 32'd0);
        check("rst_lock", {31'b0, halt_lock}, 32'd0);
        check("rst_vis", {31'b0, cpu_clk_vis}, 32'd0);
        check("rst_tick", tick_count, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean 40-cycle press: one pulse at DB+4
        step_btn = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            log_cycle(k);
            if (k == 40) step_btn = 1'b0;
        end
        scan(80, cnt, p1, p2, p3);
        check("step_count", cnt, 32'd1);
        check("step_latency", p1, DB + 4);
        check("step_tick", tick_count, 32'd1);
        check("step_vis", {31'b0, cpu_clk_vis}, 32'd1);

        // 10-cycle glitch: no pulse
        step_btn = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            log_cycle(k);
            if (k == 10) step_btn = 1'b0;
        end
        scan(60, cnt, p1, p2, p3);
        check("glitch_count", cnt, 32'd0);
        check("glitch_tick", tick_count, 32'd1);

        // Free run at RATE3
        do_reset();
        rate_sel = 2'd3;
        run_req  = 1'b1;
        for (int k = 1; k <= 80; k++) log_cycle(k);
        scan(80, cnt, p1, p2, p3);
        check("run_lat_pre", {31'b0, run_log[2]}, 32'd0);
        check("run_lat", {31'b0, run_log[3]}, 32'd1);
        check("run3_first", p1, 3 + R3);
        check("run3_second", p2, 3 + 2 * R3);
        check("run3_third", p3, 3 + 3 * R3);
        check("run3_count", cnt, 32'd3);
        check("run3_tick", tick_count, 32'd3);
        check("run3_vis", {31'b0, cpu_clk_vis}, 32'd1);

        // Rate change 2->1 while counter is at 3: first period stays R2, then R1
        do_reset();
        rate_sel = 2'd2;
        run_req  = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            log_cycle(k);
            if (k == 6) rate_sel = 2'd1;
        end
        scan(30, cnt, p1, p2, p3);
        check("rate_first", p1, 3 + R2);
        check("rate_second", p2, 3 + R2 + R1);
        check("rate_third", p3, 3 + R2 + 2 * R1);

        // Step press during RUN is ignored
        do_reset();
        rate_sel = 2'd1;
        run_req  = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            log_cycle(k);
            if (k == 10) step_btn = 1'b1;
            if (k == 50) step_btn = 1'b0;
        end
        scan(100, cnt, p1, p2, p3);
        check("runstep_count", cnt, 32'd19);
        check("runstep_first", p1, 3 + R1);
        check("runstep_tick", tick_count, 32'd19);

        // Step event and run_s arrive together in HALT: STEP first, then RUN
        do_reset();
        rate_sel = 2'd1;
        step_btn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            log_cycle(k);
            if (k == 17) run_req = 1'b1;
            if (k == 25) step_btn = 1'b0;
        end
        scan(30, cnt, p1, p2, p3);
        check("win_step_ce", {31'b0, ce_log[20]}, 32'd1);
        check("win_step_notrun", {31'b0, run_log[20]}, 32'd0);
        check("win_halt_ce", {31'b0, ce_log[21]}, 32'd0);
        check("win_halt_notrun", {31'b0, run_log[21]}, 32'd0);
        check("win_run", {31'b0, run_log[22]}, 32'd1);
        check("win_run_ce", {31'b0, ce_log[27]}, 32'd1);
        check("win_count", cnt, 32'd2);
        check("win_tick", tick_count, 32'd2);

        // Halt on a tick cycle with RATE0
        do_reset();
        rate_sel = 2'd0;
        run_req  = 1'b1;
        repeat (6) @(negedge clk);
        check("halt_pre_ce", {31'b0, cpu_ce}, 32'd1);
        check("halt_pre_tick", tick_count, 32'd3);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("halt_ce", {31'b0, cpu_ce}, 32'd0);
        check("halt_running", {31'b0, running}, 32'd0);
        check("halt_lock_set", {31'b0, halt_lock}, 32'd1);
        check("halt_tick", tick_count, 32'd3);
        seen_ce = 0;
        seen_run = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (cpu_ce) seen_ce++;
            if (running) seen_run++;
        end
        check("lock_hold_ce", seen_ce, 32'd0);
        check("lock_hold_run", seen_run, 32'd0);
        run_req = 1'b0;
        for (int k = 1; k <= 3; k++) log_cycle(k);
        check("lock_kept", {31'b0, lk_log[2]}, 32'd1);
        check("lock_clear", {31'b0, lk_log[3]}, 32'd0);
        run_req = 1'b1;
        for (int k = 1; k <= 5; k++) log_cycle(k);
        check("rerun_pre", {31'b0, run_log[2]}, 32'd0);
        check("rerun", {31'b0, run_log[3]}, 32'd1);
        check("rerun_ce", {31'b0, ce_log[4]}, 32'd1);

        // Asynchronous reset mid-RUN, between clock edges
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ce", {31'b0, cpu_ce}, 32'd0);
        check("arst_running", {31'b0, running}, 32'd0);
        check("arst_lock", {31'b0, halt_lock}, 32'd0);
        check("arst_vis", {31'b0, cpu_clk_vis}, 32'd0);
        check("arst_tick", tick_count, 32'd0);
        @(negedge clk);

        // tick_count wrap from all-ones
        do_reset();
        force dut.tick_reg = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        release dut.tick_reg;
        check("wrap_preload", tick_count, 32'hFFFF_FFFF);
        step_btn = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 19) check("wrap_before", tick_count, 32'hFFFF_FFFF);
            if (k == 20) begin
                check("wrap_ce", {31'b0, cpu_ce}, 32'd1);
                check("wrap_zero", tick_count, 32'd0);
            end
        end
        step_btn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
